// File: rtl/pq_cmd_initiator.sv
// Command-stream initiator for the priority queue push/pop/drop handshake.
// One request outstanding at a time; one response returned per command.
module pq_cmd_initiator #(
    parameter int DW      = 16,
    parameter int IW      = 4,
    parameter int TIMEOUT = 16
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cmd_valid_i,
    output logic          cmd_ready_o,
    input  logic [1:0]    cmd_op_i,
    input  logic [DW-1:0] cmd_data_i,
    input  logic [IW-1:0] cmd_id_i,
    output logic          rsp_valid_o,
    input  logic          rsp_ready_i,
    output logic [1:0]    rsp_op_o,
    output logic [DW-1:0] rsp_data_o,
    output logic [IW-1:0] rsp_id_o,
    output logic [1:0]    rsp_err_o,
    output logic          push_o,
    output logic          pop_o,
    output logic          drop_o,
    output logic [DW-1:0] q_data_o,
    output logic [IW-1:0] drop_id_o,
    input  logic          push_rdy_i,
    input  logic          pop_rdy_i,
    input  logic          drop_rdy_i,
    input  logic [IW-1:0] push_id_i,
    input  logic [DW-1:0] q_data_i,
    input  logic          full_i,
    input  logic          empty_i,
    output logic [7:0]    err_cnt_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] OP_PUSH = 2'b00;
    localparam logic [1:0] OP_POP  = 2'b01;
    localparam logic [1:0] OP_DROP = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    localparam logic [1:0] ERR_OK  = 2'b00;
    localparam logic [1:0] ERR_ILL = 2'b01;
    localparam logic [1:0] ERR_REJ = 2'b10;
    localparam logic [1:0] ERR_TMO = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    op_q;
    logic [DW-1:0] data_q;
    logic [IW-1:0] id_q;
    logic [CW-1:0] wait_q;
    logic          bad_op, rej, xfer, tmo;

    assign cmd_ready_o = (state_q == IDLE);
    assign rsp_valid_o = (state_q == RESP);
    assign q_data_o    = data_q;
    assign drop_id_o   = id_q;

    assign bad_op = (cmd_op_i == OP_ILL);
    assign rej    = ((cmd_op_i == OP_PUSH) && full_i) ||
                    ((cmd_op_i != OP_PUSH) && empty_i);
    assign xfer   = (push_o && push_rdy_i) ||
                    (pop_o && pop_rdy_i) ||
                    (drop_o && drop_rdy_i);
    // Transfer wins over a timeout landing on the same edge.
    assign tmo    = !xfer && (wait_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid_i) state_d = (bad_op || rej) ? RESP : ISSUE;
            end
            ISSUE: begin
                if (xfer || tmo) state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            op_q       <= '0;
            data_q     <= '0;
            id_q       <= '0;
            wait_q     <= '0;
            push_o     <= 1'b0;
            pop_o      <= 1'b0;
            drop_o     <= 1'b0;
            rsp_op_o   <= '0;
            rsp_data_o <= '0;
            rsp_id_o   <= '0;
            rsp_err_o  <= '0;
            err_cnt_o  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid_i) begin
                        op_q   <= cmd_op_i;
                        data_q <= cmd_data_i;
                        id_q   <= cmd_id_i;
                        wait_q <= '0;
                        if (bad_op || rej) begin
                            rsp_op_o   <= cmd_op_i;
                            rsp_err_o  <= bad_op ? ERR_ILL : ERR_REJ;
                            rsp_data_o <= '0;
                            rsp_id_o   <= (cmd_op_i == OP_DROP) ? cmd_id_i : '0;
                        end else begin
                            push_o <= (cmd_op_i == OP_PUSH);
                            pop_o  <= (cmd_op_i == OP_POP);
                            drop_o <= (cmd_op_i == OP_DROP);
                        end
                    end
                end
                ISSUE: begin
                    if (xfer || tmo) begin
                        push_o     <= 1'b0;
                        pop_o      <= 1'b0;
                        drop_o     <= 1'b0;
                        rsp_op_o   <= op_q;
                        rsp_err_o  <= xfer ? ERR_OK : ERR_TMO;
                        rsp_data_o <= (xfer && op_q == OP_POP) ? q_data_i : '0;
                        if (op_q == OP_DROP)
                            rsp_id_o <= id_q;
                        else if (xfer && op_q == OP_PUSH)
                            rsp_id_o <= push_id_i;
                        else
                            rsp_id_o <= '0;
                    end else begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        rsp_op_o   <= '0;
                        rsp_data_o <= '0;
                        rsp_id_o   <= '0;
                        rsp_err_o  <= '0;
                        if (rsp_err_o != ERR_OK && err_cnt_o != 8'hFF)
                            err_cnt_o <= err_cnt_o + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: doc/pq_cmd_initiator.md
# pq_cmd_initiator

Hardware initiator for the priority queue's push/pop/drop handshake. It accepts single commands on a valid/ready command stream and drives the queue's request strobes until the queue accepts them. It then returns one response per command, carrying the popped data or the assigned push ID and an error code. It sits between a software-visible command port or scheduler and the `pq` instance, and replaces the bench-style task sequencing with synthesizable logic.

## Interface
Parameters:
- `DW`, 16, data width; must match the queue.
- `IW`, 4, queue entry ID width.
- `TIMEOUT`, 16, consecutive not-ready cycles before an issued request is aborted; minimum 2.

Ports:
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command valid.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_op_i`  in  2  opcode: 00 push, 01 pop, 10 drop, 11 illegal.
- `cmd_data_i`  in  DW  push data.
- `cmd_id_i`  in  IW  drop ID.
- `rsp_valid_o`  out  1  response valid.
- `rsp_ready_i`  in  1  response consumed.
- `rsp_op_o`  out  2  echoed opcode.
- `rsp_data_o`  out  DW  popped data for pop, otherwise 0.
- `rsp_id_o`  out  IW  assigned ID for push, the echoed ID for drop, otherwise 0.
- `rsp_err_o`  out  2  error code: 00 ok, 01 illegal op, 10 rejected (full/empty), 11 timeout.
- `push_o`, `pop_o`, `drop_o`  out  1 each  queue request strobes.
- `q_data_o`  out  DW  push data to the queue.
- `drop_id_o`  out  IW  drop ID to the queue.
- `push_rdy_i`, `pop_rdy_i`, `drop_rdy_i`  in  1 each  queue ready signals.
- `push_id_i`  in  IW  ID assigned by the queue; valid in the push transfer cycle.
- `q_data_i`  in  DW  pop data from the queue; valid in the pop transfer cycle.
- `full_i`, `empty_i`  in  1 each  queue status.
- `err_cnt_o`  out  8  saturating count of non-ok responses.

## Operation
The block has three states: IDLE, ISSUE and RESP.

- **IDLE**
  - `cmd_ready_o` is 1 in this state only.
  - On a command handshake, the block latches op, data and ID.
  - Op 11 goes to RESP with error 01.
  - A push while `full_i` is high, or a pop or drop while `empty_i` is high, goes to RESP with error 10. No strobe is asserted in these cases.
  - Any other command goes to ISSUE.
- **ISSUE**
  - Exactly one strobe is high, chosen by the latched op.
  - `q_data_o` and `drop_id_o` are held stable from the latched fields.
  - A transfer happens on a rising edge where the strobe and its matching ready are both high.
  - On transfer, the block captures `push_id_i` (push) or `q_data_i` (pop), then goes to RESP with error 00.
  - The wait counter counts cycles with ready low. When it reaches `TIMEOUT`, the strobe drops on that edge and the block goes to RESP with error 11.
- **RESP**
  - `rsp_valid_o` is 1 and all `rsp_*` fields are stable.
  - The block returns to IDLE on the `rsp_ready_i` edge.
- `full_i` and `empty_i` are sampled only at command acceptance. Later changes during ISSUE are ignored.
- `err_cnt_o` increments by 1 on each response handshake with a non-zero error and saturates at 255.
- Strobes are registered outputs: they are low in IDLE and RESP, and high in ISSUE.

## Timing
- Reset values:
  - state is IDLE, so `cmd_ready_o` = 1.
  - All other outputs are 0, including the strobes, `rsp_*` and `err_cnt_o`.
  - The wait counter is 0.
- An asserted reset during ISSUE or RESP aborts immediately. The strobes drop asynchronously and the pending response is lost.
- Command accepted at edge N:
  - Strobe is high during cycle N..N+1.
  - If ready is already high, the transfer happens at edge N+1.
  - `rsp_valid_o` rises after edge N+1.
  - Minimum command-to-command period is 3 cycles, with `rsp_ready_i` tied high.
- Rejected or illegal commands: `rsp_valid_o` rises after edge N with no strobe activity.
- Timeout: with ready held low, the strobe is high for exactly `TIMEOUT` cycles, then `rsp_valid_o` rises.
- A ready that rises in the same cycle the counter would reach `TIMEOUT` counts as a transfer; transfer takes priority over timeout.
- The wait counter clears on every entry to ISSUE.
- Only one request is ever outstanding, and no new command is accepted until the response handshake completes.
- `rsp_ready_i` held low keeps the block in RESP indefinitely with all outputs stable.

## Test plan
- **Pushes then pops:** push 0xF0, 0x15, 0x87 against a queue model with ready always high, then pop ×3.
  - Responses are ok, with IDs 0, 1, 2.
  - Pops return 0x15, 0x87, 0xF0.
  - Each command takes 3 cycles.
- **Drop:** push 0x01, 0xEB, 0xAF, then drop ID 2.
  - `drop_o` is high one cycle with `drop_id_o` = 2.
  - Response is ok with `rsp_id_o` = 2.
  - A following pop returns 0x01.
- **Reject on status:** pop with `empty_i` = 1, and push with `full_i` = 1.
  - Error is 10 and no strobe is asserted.
  - `err_cnt_o` goes 0→1→2.
- **Ready stall and timeout:** hold `pop_rdy_i` low for 5 cycles then raise it (`TIMEOUT` = 16).
  - `pop_o` is high for 6 cycles, ending in an ok response.
  - With `push_rdy_i` low forever, `push_o` is high for 16 cycles, the error is 11 and `push_o` drops.
- **Backpressure and illegal op:** send op 11 while `rsp_ready_i` is held low for 4 cycles.
  - `rsp_valid_o` stays high with error 01.
  - `cmd_ready_o` stays 0 until the response handshake.
- **Mid-operation reset:** assert `rst_ni` low while `push_o` is high.
  - All strobes and `rsp_valid_o` fall immediately.
  - After release, `cmd_ready_o` = 1 and `err_cnt_o` = 0.
